// File: rtl/mac_input_skewer.sv
// mac_input_skewer: input feeder for the systolic MAC array.
// Accepts one row of ARR_SIZE operands per beat and delays lane i by i
// cycles so the array receives a diagonal wavefront on its horizontal
// input. After the last beat of a burst the skew pipeline is drained with
// zero bubbles and done pulses when the top lane of that beat is on out_data.
module mac_input_skewer #(
    parameter int ARR_SIZE      = 4,
    parameter int HORIZONTAL_BW = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              in_last,
    input  logic [HORIZONTAL_BW*ARR_SIZE-1:0] in_data,
    output logic [HORIZONTAL_BW*ARR_SIZE-1:0] out_data,
    output logic [ARR_SIZE-1:0]               out_lane_valid,
    output logic                              out_mode,
    output logic                              busy,
    output logic                              done
);

    // Drain counter only has to reach ARR_SIZE-2; keep it at least one bit wide.
    localparam int CW = (ARR_SIZE > 2) ? $clog2(ARR_SIZE - 1) : 1;
    localparam logic [CW-1:0] DRAIN_LAST = CW'((ARR_SIZE > 1) ? ARR_SIZE - 2 : 0);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   drain_cnt_q, drain_cnt_d;
    logic            done_q, done_d;
    logic            accept;
    logic [ARR_SIZE-1:0] lane_busy;

    // Ready depends on state alone so it never loops back through in_valid.
    assign in_ready = (state_q != DRAIN);
    assign accept   = in_valid && in_ready;

    // Next-state, drain counter and done pulse for the burst controller.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        done_d      = 1'b0;
        unique case (state_q)
            IDLE, STREAM: begin
                if (accept) begin
                    if (in_last) begin
                        if (ARR_SIZE == 1) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d     = DRAIN;
                            drain_cnt_d = '0;
                        end
                    end else begin
                        state_d = STREAM;
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d     = IDLE;
                    drain_cnt_d = '0;
                    done_d      = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d     = IDLE;
                drain_cnt_d = '0;
            end
        endcase
    end

    // Controller registers; reset discards any burst in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            drain_cnt_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            done_q      <= done_d;
        end
    end

    assign done = done_q;

    // One delay line per lane: lane i is a chain of i+1 data/tag registers.
    for (genvar i = 0; i < ARR_SIZE; i++) begin : g_lane
        logic [HORIZONTAL_BW-1:0] data_q [i+1];
        logic [HORIZONTAL_BW-1:0] data_d [i+1];
        logic [i:0]               tag_q;
        logic [i:0]               tag_d;

        // Head takes the accepted operand or a zero bubble; the rest shift.
        always_comb begin
            data_d[0] = accept ? in_data[i*HORIZONTAL_BW +: HORIZONTAL_BW] : '0;
            tag_d[0]  = accept;
            for (int j = 1; j <= i; j++) begin
                data_d[j] = data_q[j-1];
                tag_d[j]  = tag_q[j-1];
            end
        end

        // Delay-line registers for this lane.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int j = 0; j <= i; j++) begin
                    data_q[j] <= '0;
                end
                tag_q <= '0;
            end else begin
                data_q <= data_d;
                tag_q  <= tag_d;
            end
        end

        assign out_data[i*HORIZONTAL_BW +: HORIZONTAL_BW] = tag_q[i] ? data_q[i] : '0;
        assign out_lane_valid[i] = tag_q[i];
        assign lane_busy[i]      = |tag_q;
    end

    assign out_mode = |out_lane_valid;
    assign busy     = (state_q != IDLE) || (|lane_busy);

endmodule

// File: tb/tb_mac_input_skewer.sv
// Directed bench for mac_input_skewer: a 4-lane instance for the burst,
// bubble, hold-off and reset scenarios, plus a 1-lane instance for the
// degenerate corner where there is no drain phase.
module tb_mac_input_skewer;

    logic        clk;
    logic        rst;

    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [63:0] in_data;
    logic [63:0] out_data;
    logic [3:0]  out_lane_valid;
    logic        out_mode;
    logic        busy;
    logic        done;

    logic        in_valid1;
    logic        in_ready1;
    logic        in_last1;
    logic [15:0] in_data1;
    logic [15:0] out_data1;
    logic [0:0]  out_lane_valid1;
    logic        out_mode1;
    logic        busy1;
    logic        done1;

    int passCount;
    int failCount;
    int checkCount;

    mac_input_skewer #(.ARR_SIZE(4), .HORIZONTAL_BW(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_last        (in_last),
        .in_data        (in_data),
        .out_data       (out_data),
        .out_lane_valid (out_lane_valid),
        .out_mode       (out_mode),
        .busy           (busy),
        .done           (done)
    );

    mac_input_skewer #(.ARR_SIZE(1), .HORIZONTAL_BW(16)) dut1 (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid1),
        .in_ready       (in_ready1),
        .in_last        (in_last1),
        .in_data        (in_data1),
        .out_data       (out_data1),
        .out_lane_valid (out_lane_valid1),
        .out_mode       (out_mode1),
        .busy           (busy1),
        .done           (done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] pack(input logic [15:0] l3, input logic [15:0] l2,
                                         input logic [15:0] l1, input logic [15:0] l0);
        return {l3, l2, l1, l0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic l, input logic [63:0] d);
        in_valid = v;
        in_last  = l;
        in_data  = d;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", name, observed, expected);
        end
    endtask

    // Compare the whole 4-lane output bundle against hand-computed values.
    task automatic checkLanes(input string name, input logic [63:0] expData,
                              input logic [3:0] expLv, input logic expDone,
                              input logic expReady);
        checkOutput({name, ".data"},  out_data, expData);
        checkOutput({name, ".lv"},    64'(out_lane_valid), 64'(expLv));
        checkOutput({name, ".mode"},  64'(out_mode), 64'(|expLv));
        checkOutput({name, ".done"},  64'(done), 64'(expDone));
        checkOutput({name, ".ready"}, 64'(in_ready), 64'(expReady));
    endtask

    initial begin
        int doneSeen;
        passCount  = 0;
        failCount  = 0;
        checkCount = 0;
        rst        = 1'b0;
        applyStimulus(1'b0, 1'b0, 64'h0);
        in_valid1  = 1'b0;
        in_last1   = 1'b0;
        in_data1   = 16'h0;

        // Reset state
        tick();
        tick();
        checkLanes("rst_hold", 64'h0, 4'b0000, 1'b0, 1'b1);
        checkOutput("rst_hold.busy", 64'(busy), 64'h0);
        rst = 1'b1;
        #1;
        checkLanes("rst_rel", 64'h0, 4'b0000, 1'b0, 1'b1);
        checkOutput("rst_rel.busy", 64'(busy), 64'h0);

        // Single-beat burst
        applyStimulus(1'b1, 1'b1, pack(4, 3, 2, 1));
        tick();
        applyStimulus(1'b0, 1'b0, 64'h0);
        checkLanes("single.E0", pack(0, 0, 0, 1), 4'b0001, 1'b0, 1'b0);
        checkOutput("single.E0.busy", 64'(busy), 64'h1);
        tick();
        checkLanes("single.E1", pack(0, 0, 2, 0), 4'b0010, 1'b0, 1'b0);
        tick();
        checkLanes("single.E2", pack(0, 3, 0, 0), 4'b0100, 1'b0, 1'b0);
        tick();
        checkLanes("single.E3", pack(4, 0, 0, 0), 4'b1000, 1'b1, 1'b1);
        checkOutput("single.E3.busy", 64'(busy), 64'h1);
        tick();
        checkLanes("single.E4", 64'h0, 4'b0000, 1'b0, 1'b1);
        checkOutput("single.E4.busy", 64'(busy), 64'h0);

        // Back-to-back burst of three beats
        applyStimulus(1'b1, 1'b0, pack(4, 3, 2, 1));
        tick();
        checkLanes("b2b.E0", pack(0, 0, 0, 1), 4'b0001, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, pack(8, 7, 6, 5));
        tick();
        checkLanes("b2b.E1", pack(0, 0, 2, 5), 4'b0011, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, pack(12, 11, 10, 9));
        tick();
        applyStimulus(1'b0, 1'b0, 64'h0);
        checkLanes("b2b.E2", pack(0, 3, 6, 9), 4'b0111, 1'b0, 1'b0);
        tick();
        checkLanes("b2b.E3", pack(4, 7, 10, 0), 4'b1110, 1'b0, 1'b0);
        tick();
        checkLanes("b2b.E4", pack(8, 11, 0, 0), 4'b1100, 1'b0, 1'b0);
        tick();
        checkLanes("b2b.E5", pack(12, 0, 0, 0), 4'b1000, 1'b1, 1'b1);
        tick();
        checkOutput("b2b.E6.busy", 64'(busy), 64'h0);

        // Bubble inside STREAM
        applyStimulus(1'b1, 1'b0, pack(4, 3, 2, 1));
        tick();
        checkLanes("bub.E0", pack(0, 0, 0, 1), 4'b0001, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, pack(16'hDEAD, 16'hDEAD, 16'hDEAD, 16'hDEAD));
        tick();
        checkLanes("bub.E1", pack(0, 0, 2, 0), 4'b0010, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, pack(8, 7, 6, 5));
        tick();
        applyStimulus(1'b0, 1'b0, 64'h0);
        checkLanes("bub.E2", pack(0, 3, 0, 5), 4'b0101, 1'b0, 1'b0);
        tick();
        checkLanes("bub.E3", pack(4, 0, 6, 0), 4'b1010, 1'b0, 1'b0);
        tick();
        checkLanes("bub.E4", pack(0, 7, 0, 0), 4'b0100, 1'b0, 1'b0);
        tick();
        checkLanes("bub.E5", pack(8, 0, 0, 0), 4'b1000, 1'b1, 1'b1);
        tick();
        checkOutput("bub.E6.busy", 64'(busy), 64'h0);

        // Hold-off during DRAIN: the FFFF beat waits until ready returns
        applyStimulus(1'b1, 1'b1, pack(4, 3, 2, 1));
        tick();
        applyStimulus(1'b1, 1'b1, pack(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF));
        checkLanes("hold.E0", pack(0, 0, 0, 1), 4'b0001, 1'b0, 1'b0);
        tick();
        checkLanes("hold.E1", pack(0, 0, 2, 0), 4'b0010, 1'b0, 1'b0);
        tick();
        checkLanes("hold.E2", pack(0, 3, 0, 0), 4'b0100, 1'b0, 1'b0);
        tick();
        checkLanes("hold.E3", pack(4, 0, 0, 0), 4'b1000, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 64'h0);
        checkLanes("hold.E4", pack(0, 0, 0, 16'hFFFF), 4'b0001, 1'b0, 1'b0);
        tick();
        checkLanes("hold.E5", pack(0, 0, 16'hFFFF, 0), 4'b0010, 1'b0, 1'b0);
        tick();
        checkLanes("hold.E6", pack(0, 16'hFFFF, 0, 0), 4'b0100, 1'b0, 1'b0);
        tick();
        checkLanes("hold.E7", pack(16'hFFFF, 0, 0, 0), 4'b1000, 1'b1, 1'b1);
        tick();
        checkOutput("hold.E8.busy", 64'(busy), 64'h0);

        // Reset in the middle of a three-beat burst
        applyStimulus(1'b1, 1'b0, pack(4, 3, 2, 1));
        tick();
        applyStimulus(1'b1, 1'b0, pack(8, 7, 6, 5));
        tick();
        checkLanes("mrst.E1", pack(0, 0, 2, 5), 4'b0011, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, pack(12, 11, 10, 9));
        #3;
        rst = 1'b0;
        #1;
        checkLanes("mrst.async", 64'h0, 4'b0000, 1'b0, 1'b1);
        checkOutput("mrst.async.busy", 64'(busy), 64'h0);
        applyStimulus(1'b0, 1'b0, 64'h0);
        tick();
        rst = 1'b1;
        doneSeen = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (done === 1'b1 || out_mode !== 1'b0) doneSeen++;
        end
        checkOutput("mrst.no_done", 64'(doneSeen), 64'h0);
        checkLanes("mrst.idle", 64'h0, 4'b0000, 1'b0, 1'b1);

        // ARR_SIZE=1 corner
        checkOutput("one.ready0", 64'(in_ready1), 64'h1);
        in_valid1 = 1'b1;
        in_last1  = 1'b1;
        in_data1  = 16'hABCD;
        tick();
        in_valid1 = 1'b0;
        in_last1  = 1'b0;
        in_data1  = 16'h0;
        checkOutput("one.E0.data",  64'(out_data1), 64'hABCD);
        checkOutput("one.E0.done",  64'(done1), 64'h1);
        checkOutput("one.E0.lv",    64'(out_lane_valid1), 64'h1);
        checkOutput("one.E0.ready", 64'(in_ready1), 64'h1);
        tick();
        checkOutput("one.E1.data",  64'(out_data1), 64'h0);
        checkOutput("one.E1.done",  64'(done1), 64'h0);
        checkOutput("one.E1.ready", 64'(in_ready1), 64'h1);
        checkOutput("one.E1.busy",  64'(busy1), 64'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
